dii_instr_feeder: RTL and testbench

DII_INSTR_FEEDER -- requirements
Module: dii_instr_feeder

---
 rtl/dii_instr_feeder.sv | 162 ++++++++++++++++
 tb/tb_dii_instr_feeder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dii_instr_feeder.sv
// DII instruction feeder: assembles 8-byte host packets into instructions,
// queues them for the core and sequences a core reset at end-of-trace.
module dii_instr_feeder #(
   parameter int FIFO_DEPTH   = 4,
   parameter int RESET_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        core_rst_req,
   output logic [7:0]  bad_cmd_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int HC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [HC_W-1:0]  HC_ONE   = HC_W'(1);
   localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(RESET_CYCLES - 1);

   localparam logic [7:0] CMD_EOT  = 8'h00;
   localparam logic [7:0] CMD_INSN = 8'h01;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t             state;
   logic [2:0]         byte_idx;
   logic [31:0]        insn_q;
   logic [7:0]         cmd_q;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_next;
   logic [HC_W-1:0]    halt_cnt;
   logic               core_rst_q;
   logic [7:0]         bad_q;
   logic [31:0]        mem [FIFO_DEPTH];

   logic fifo_full;
   logic rx_fire;
   logic pkt_done;
   logic push;
   logic eot;
   logic bad_pkt;
   logic pop;

   // Full is taken from the registered count, so a same-cycle pop cannot
   // open room for the byte that would complete a push.
   assign fifo_full = (count == CNT_FULL);
   assign rx_ready  = (state == S_RUN) && !((byte_idx == 3'd7) && fifo_full);
   assign rx_fire   = rx_valid && rx_ready;
   assign pkt_done  = rx_fire && (byte_idx == 3'd7);
   assign push      = pkt_done && (cmd_q == CMD_INSN);
   assign eot       = pkt_done && (cmd_q == CMD_EOT);
   assign bad_pkt   = pkt_done && (cmd_q != CMD_INSN) && (cmd_q != CMD_EOT);

   assign instr_valid  = (count != '0) && (state != S_HALT);
   assign instr        = instr_valid ? mem[rd_ptr] : 32'h0;
   assign pop          = instr_valid && instr_ready;
   assign core_rst_req = core_rst_q;
   assign bad_cmd_cnt  = bad_q;

   always_comb begin
      // NOTE: default first so every path assigns count_next and no latch is inferred.
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_ONE;
         2'b01:   count_next = count - CNT_ONE;
         default: count_next = count;
      endcase
   end

   // NOTE: queue storage carries no reset; count and pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= insn_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RUN;
         byte_idx   <= 3'd0;
         insn_q     <= 32'h0;
         cmd_q      <= 8'h00;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         halt_cnt   <= '0;
         core_rst_q <= 1'b0;
         bad_q      <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
         if (rx_fire) begin
            byte_idx <= byte_idx + 3'd1;
            case (byte_idx)
               3'd0:    insn_q[7:0]   <= rx_data;
               3'd1:    insn_q[15:8]  <= rx_data;
               3'd2:    insn_q[23:16] <= rx_data;
               3'd3:    insn_q[31:24] <= rx_data;
               3'd6:    cmd_q         <= rx_data;
               default: ;
            endcase
         end

         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count <= count_next;

         if (bad_pkt && (bad_q != 8'hFF)) begin
            bad_q <= bad_q + 8'd1;
         end

         case (state)
            S_RUN: begin
               if (eot) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // A pop that empties the queue this cycle still counts as drained.
               if (count_next == '0) begin
                  state      <= S_HALT;
                  halt_cnt   <= '0;
                  core_rst_q <= 1'b1;
               end
            end
            S_HALT: begin
               if (halt_cnt == HC_LAST) begin
                  state      <= S_RUN;
                  halt_cnt   <= '0;
                  core_rst_q <= 1'b0;
                  byte_idx   <= 3'd0;
               end else begin
                  halt_cnt <= halt_cnt + HC_ONE;
               end
            end
            default: begin
               state      <= S_RUN;
               core_rst_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dii_instr_feeder.sv
// Randomized bench for dii_instr_feeder: a queue-based packet model predicts
// every output each cycle, with directed scenarios for queue, drain and reset.
module tb_dii_instr_feeder;

   localparam int DEPTH = 4;
   localparam int RC    = 4;
   localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        core_rst_req;
   logic [7:0]  bad_cmd_cnt;

   dii_instr_feeder #(.FIFO_DEPTH(DEPTH), .RESET_CYCLES(RC)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .core_rst_req (core_rst_req),
      .bad_cmd_cnt  (bad_cmd_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model: the packet in progress, the instruction queue and the trace phase.
   logic [31:0] mq[$];
   logic [7:0]  pk[8];
   int          pidx, mode, hcnt, mbad;
   bit          model_ok = 0;
   bit          last_fire;
   int          rdy_mode = 0;   // 0: never ready, 1: always ready, 2: random
   bit          gaps = 0;

   function automatic bit exp_rx_ready();
      return (mode == M_RUN) && !(pidx == 7 && mq.size() == DEPTH);
   endfunction

   function automatic bit exp_valid();
      return (mq.size() != 0) && (mode != M_HALT);
   endfunction

   function automatic logic [31:0] exp_instr();
      return exp_valid() ? mq[0] : 32'h0;
   endfunction

   task automatic model_reset();
      mq.delete();
      pidx = 0; mode = M_RUN; hcnt = 0; mbad = 0;
      model_ok = 1;
   endtask

   task automatic model_step(input bit fire, input bit pop, input logic [7:0] d);
      int  prev_mode = mode;
      bit  end_trace = 0;
      if (pop) void'(mq.pop_front());
      if (fire) begin
         pk[pidx] = d;
         if (pidx == 7) begin
            if (pk[6] == 8'h01)      mq.push_back({pk[3], pk[2], pk[1], pk[0]});
            else if (pk[6] == 8'h00) end_trace = 1;
            else if (mbad < 255)     mbad++;
         end
         pidx = (pidx + 1) % 8;
      end
      case (prev_mode)
         M_RUN:   if (end_trace) mode = M_DRAIN;
         M_DRAIN: if (mq.size() == 0) begin mode = M_HALT; hcnt = 0; end
         default: begin
            hcnt++;
            if (hcnt == RC) begin mode = M_RUN; pidx = 0; end
         end
      endcase
   endtask

   // One clock: compare outputs at mid-cycle, then advance the model on the edge.
   task automatic cycle();
      bit fire, pop, r;
      logic [7:0] d;
      case (rdy_mode)
         0:       instr_ready = 1'b0;
         1:       instr_ready = 1'b1;
         default: instr_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (model_ok) begin
         check("rx_ready",     32'(rx_ready),     32'(exp_rx_ready()));
         check("instr_valid",  32'(instr_valid),  32'(exp_valid()));
         check("instr",        instr,             exp_instr());
         check("core_rst_req", 32'(core_rst_req), 32'(mode == M_HALT));
         check("bad_cmd_cnt",  32'(bad_cmd_cnt),  32'(mbad));
      end
      fire = rx_valid && exp_rx_ready();
      pop  = instr_ready && exp_valid();
      d    = rx_data;
      r    = rst;
      last_fire = fire && !r;
      @(posedge clk);
      if (r) model_reset();
      else if (model_ok) model_step(fire, pop, d);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (n) cycle();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done = 0;
      if (gaps) idle($urandom_range(0, 2));
      rx_valid = 1'b1;
      rx_data  = b;
      for (int n = 0; n < 300 && !done; n++) begin
         cycle();
         done = last_fire;
      end
      if (!done) check("byte_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] insn, input logic [7:0] cmd, input bit pop_last);
      int saved = rdy_mode;
      send_byte(insn[7:0]);
      send_byte(insn[15:8]);
      send_byte(insn[23:16]);
      send_byte(insn[31:24]);
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      send_byte(cmd);
      if (pop_last) rdy_mode = 1;
      send_byte(8'($urandom));
      rdy_mode = saved;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("rst_rx_ready",     32'(rx_ready),     32'd1);
      check("rst_instr_valid",  32'(instr_valid),  32'd0);
      check("rst_instr",        instr,             32'h0);
      check("rst_core_rst_req", 32'(core_rst_req), 32'd0);
      check("rst_bad_cmd_cnt",  32'(bad_cmd_cnt),  32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w [5];
      int          n;
      logic [7:0]  c;
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; instr_ready = 1'b0;
      @(negedge clk);
      idle(1);
      do_reset();

      // Single instruction held while the core stalls.
      rdy_mode = 0;
      send_pkt(32'h0000_0013, 8'h01, 0);
      check("first_valid", 32'(instr_valid), 32'd1);
      check("first_instr", instr, 32'h0000_0013);
      idle(3);
      check("held_instr", instr, 32'h0000_0013);
      rdy_mode = 1; idle(1); rdy_mode = 0;
      check("popped_valid", 32'(instr_valid), 32'd0);

      // Fill the queue; the fifth packet stalls on its last byte until a pop.
      for (int i = 0; i < 5; i++) w[i] = $urandom;
      for (int i = 0; i < 4; i++) send_pkt(w[i], 8'h01, 0);
      send_byte(w[4][7:0]); send_byte(w[4][15:8]);
      send_byte(w[4][23:16]); send_byte(w[4][31:24]);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      rx_valid = 1'b1; rx_data = 8'h00;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("full_stall", 32'(rx_ready), 32'd0);
      end
      rdy_mode = 1; cycle(); rdy_mode = 0;
      send_byte(8'h00);
      check("fifth_queued_head", instr, w[1]);
      rdy_mode = 1; idle(6); rdy_mode = 0;

      // End-of-trace with two queued, then a RESET_CYCLES-long core reset.
      send_pkt($urandom, 8'h01, 0);
      send_pkt($urandom, 8'h01, 0);
      send_pkt($urandom, 8'h00, 0);
      check("eot_rx_ready", 32'(rx_ready), 32'd0);
      rdy_mode = 1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (core_rst_req === 1'b1) n++;
      end
      check("halt_len", n, RC);
      check("post_halt_ready", 32'(rx_ready), 32'd1);

      // Unknown commands are dropped and counted, saturating.
      rdy_mode = 0;
      send_pkt($urandom, 8'h07, 0);
      idle(1);
      check("bad_one", 32'(bad_cmd_cnt), 32'd1);
      check("bad_no_push", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 299; i++) send_pkt($urandom, 8'($urandom_range(2, 255)), 0);
      idle(1);
      check("bad_saturated", 32'(bad_cmd_cnt), 32'd255);

      // Reset mid-packet, then a fresh packet.
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      do_reset();
      send_pkt(32'hCAFE_F00D, 8'h01, 0);
      check("fresh_instr", instr, 32'hCAFE_F00D);
      rdy_mode = 1; idle(2);

      // Reset during HALT.
      send_pkt(32'h0, 8'h00, 0);
      for (int i = 0; i < 20 && mode != M_HALT; i++) idle(1);
      check("reached_halt", 32'(mode), 32'(M_HALT));
      idle(1);
      do_reset();

      // Steady state: two queued, each new push meets a pop in the same cycle.
      rdy_mode = 0;
      send_pkt($urandom, 8'h01, 0);
      send_pkt($urandom, 8'h01, 0);
      for (int i = 0; i < 24; i++) send_pkt($urandom, 8'h01, 1);
      rdy_mode = 1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if (instr_valid === 1'b1) n++;
         idle(1);
      end
      check("steady_depth", n, 2);

      // Random traffic with stalls, gaps and mixed commands.
      rdy_mode = 2; gaps = 1;
      for (int i = 0; i < 150; i++) begin
         n = $urandom_range(0, 99);
         c = (n < 6) ? 8'h00 : (n < 14) ? 8'($urandom_range(2, 255)) : 8'h01;
         send_pkt($urandom, c, 0);
      end
      rdy_mode = 1; gaps = 0;
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
